mandelbrot_cfg_sequencer: RTL



---
 rtl/mandelbrot_cfg_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mandelbrot_cfg_sequencer.sv
// Serial configuration loader for the tinymandelbrot core.
// Shifts a default word after reset, then accepts run-time words over a
// valid/ready port and drives the core's enable/sdata/sclk pins LSB first.
module mandelbrot_cfg_sequencer #(
  parameter int unsigned          CFG_WIDTH   = 33,
  parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = CFG_WIDTH'(33'h03CF10404),
  parameter int unsigned          HALF_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 cfg_enable,
  output logic                 cfg_sdata,
  output logic                 cfg_sclk,
  output logic                 busy,
  output logic                 done,
  output logic                 loaded
);

  localparam int unsigned BIT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam int unsigned PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_WIDTH - 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FINISH
  } state_e;

  state_e               state_q;
  logic [CFG_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]     bit_q;
  logic [PH_W-1:0]      ph_q;

  logic                 load_go_c;
  logic [CFG_WIDTH-1:0] load_word_c;

  // Boot load behaves exactly like a handshake carrying the default word.
  always_comb begin
    load_go_c   = 1'b0;
    load_word_c = cfg_data;
    if (state_q == S_BOOT) begin
      load_go_c   = 1'b1;
      load_word_c = DEFAULT_CFG;
    end else if (state_q == S_IDLE && cfg_valid && cfg_ready) begin
      load_go_c   = 1'b1;
    end
  end

  // Sequencer FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      shift_q    <= '0;
      bit_q      <= '0;
      ph_q       <= '0;
      cfg_ready  <= 1'b0;
      cfg_enable <= 1'b0;
      cfg_sdata  <= 1'b0;
      cfg_sclk   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_BOOT, S_IDLE: begin
          if (load_go_c) begin
            shift_q    <= load_word_c;
            cfg_sdata  <= load_word_c[0];
            cfg_enable <= 1'b1;
            cfg_sclk   <= 1'b0;
            busy       <= 1'b1;
            cfg_ready  <= 1'b0;
            bit_q      <= '0;
            ph_q       <= '0;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          cfg_sclk <= 1'b1;
          ph_q     <= '0;
          state_q  <= S_HIGH;
        end
        S_HIGH: begin
          if (ph_q == LAST_PH) begin
            // Data advances together with the falling sclk edge.
            cfg_sclk  <= 1'b0;
            shift_q   <= shift_q >> 1;
            cfg_sdata <= shift_q[1];
            ph_q      <= '0;
            state_q   <= S_LOW;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_LOW: begin
          if (ph_q == LAST_PH) begin
            ph_q <= '0;
            if (bit_q == LAST_BIT) begin
              cfg_enable <= 1'b0;
              cfg_sdata  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              loaded     <= 1'b1;
              state_q    <= S_FINISH;
            end else begin
              bit_q    <= bit_q + BIT_W'(1);
              cfg_sclk <= 1'b1;
              state_q  <= S_HIGH;
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_FINISH: begin
          cfg_ready <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

endmodule
